// File: rtl/aes128_pkg.sv
// Shared types and constants for the AES-128 round sequencer.
package aes128_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ARK0,
    ST_SB,
    ST_SR,
    ST_MC,
    ST_WAIT_KS,
    ST_ARK,
    ST_DONE,
    ST_ERROR
  } aes_round_state_t;

  localparam logic [7:0] AES_RCON_INIT = 8'h01;
  localparam logic [7:0] AES_RCON_POLY = 8'h1B;

  function automatic logic [7:0] aes_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes128_watchdog.sv
// Saturating cycle counter; expire_o flags TIMEOUT_CYCLES elapsed since clear.
module aes128_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES);

  logic [W-1:0] cnt_q, cnt_d, cnt_now;

  // The clearing cycle counts as cycle zero of the new wait.
  always_comb begin
    cnt_now  = clear_i ? '0 : cnt_q;
    expire_o = en_i && (cnt_now == LIMIT);
    cnt_d    = cnt_now;
    if (en_i && (cnt_now != LIMIT)) begin
      cnt_d = cnt_now + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/aes128_round_ctrl.sv
// AES-128 round sequencer: start/done handshakes, round count, Rcon, watchdog.
module aes128_round_ctrl
  import aes128_pkg::*;
#(
  parameter int NUM_ROUNDS     = 10,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic [3:0] round_o,
  output logic [7:0] rcon_o,
  output logic       sb_start_o,
  output logic       sr_start_o,
  output logic       mc_start_o,
  output logic       ark_start_o,
  output logic       ks_start_o,
  input  logic       sb_done_i,
  input  logic       sr_done_i,
  input  logic       mc_done_i,
  input  logic       ark_done_i,
  input  logic       ks_done_i
);

  localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

  aes_round_state_t state_q, state_d;
  logic       first_q;
  logic [3:0] round_q, round_d;
  logic [7:0] rcon_q, rcon_d;
  logic       ks_ok_q, ks_ok_d;

  logic in_ark0, in_sb, in_sr, in_mc, in_wks, in_ark;
  logic step_wait, ks_win, ks_seen;
  logic step_exp, ks_exp;

  assign in_ark0 = (state_q == ST_ARK0);
  assign in_sb   = (state_q == ST_SB);
  assign in_sr   = (state_q == ST_SR);
  assign in_mc   = (state_q == ST_MC);
  assign in_wks  = (state_q == ST_WAIT_KS);
  assign in_ark  = (state_q == ST_ARK);

  assign step_wait = in_ark0 | in_sb | in_sr | in_mc | in_ark;
  assign ks_win    = in_sb | in_sr | in_mc | in_wks;
  assign ks_seen   = ks_ok_q | ks_done_i;

  assign sb_start_o  = in_sb & first_q;
  assign ks_start_o  = in_sb & first_q;
  assign sr_start_o  = in_sr & first_q;
  assign mc_start_o  = in_mc & first_q;
  assign ark_start_o = (in_ark0 | in_ark) & first_q;

  assign busy_o  = step_wait | in_wks | (state_q == ST_DONE);
  assign done_o  = (state_q == ST_DONE);
  assign err_o   = (state_q == ST_ERROR);
  assign round_o = round_q;
  assign rcon_o  = rcon_q;

  aes128_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_step_wd (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (step_wait & first_q),
    .en_i    (step_wait),
    .expire_o(step_exp)
  );

  // Key expansion is timed from its own start, across the whole round.
  aes128_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_ks_wd (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (ks_start_o),
    .en_i    (ks_win & ~ks_ok_q),
    .expire_o(ks_exp)
  );

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    rcon_d  = rcon_q;
    ks_ok_d = ks_ok_q | (ks_win & ks_done_i);
    unique case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (start_i) begin
          state_d = ST_ARK0;
          round_d = '0;
          rcon_d  = AES_RCON_INIT;
          ks_ok_d = 1'b0;
        end
      end
      ST_ARK0: begin
        if (ark_done_i) begin
          round_d = 4'd1;
          state_d = ST_SB;
        end else if (step_exp) begin
          state_d = ST_ERROR;
        end
      end
      ST_SB: begin
        if (sb_done_i) state_d = ST_SR;
        else if (step_exp) state_d = ST_ERROR;
      end
      ST_SR: begin
        if (sr_done_i) begin
          if (round_q < LAST) state_d = ST_MC;
          else if (ks_seen) state_d = ST_ARK;
          else state_d = ST_WAIT_KS;
        end else if (step_exp) begin
          state_d = ST_ERROR;
        end
      end
      ST_MC: begin
        if (mc_done_i) state_d = ks_seen ? ST_ARK : ST_WAIT_KS;
        else if (step_exp) state_d = ST_ERROR;
      end
      ST_WAIT_KS: begin
        if (ks_seen) state_d = ST_ARK;
        else if (ks_exp) state_d = ST_ERROR;
      end
      ST_ARK: begin
        ks_ok_d = 1'b0;
        if (ark_done_i) begin
          if (round_q == LAST) begin
            state_d = ST_DONE;
          end else begin
            round_d = round_q + 4'd1;
            rcon_d  = aes_xtime(rcon_q);
            state_d = ST_SB;
          end
        end else if (step_exp) begin
          state_d = ST_ERROR;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      first_q <= 1'b0;
      round_q <= '0;
      rcon_q  <= AES_RCON_INIT;
      ks_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= (state_d != state_q);
      round_q <= round_d;
      rcon_q  <= rcon_d;
      ks_ok_q <= ks_ok_d;
    end
  end

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// Self-checking bench for aes128_round_ctrl with latency-programmable unit models.
module tb_aes128_round_ctrl;

  localparam int N  = 10;
  localparam int TO = 64;

  typedef struct {
    int lsb, lsr, lmc, lark, lks, inj;
    int nsb, nsr, nmc, nark, nks;
  } vec_t;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic start_main = 1'b0;
  logic start_inj = 1'b0;
  logic sr_spur = 1'b0;
  logic start_i;
  logic busy_o, done_o, err_o;
  logic [3:0] round_o;
  logic [7:0] rcon_o;
  logic sb_start_o, sr_start_o, mc_start_o, ark_start_o, ks_start_o;
  logic sb_done_i, sr_done_i, mc_done_i, ark_done_i, ks_done_i;
  logic [4:0] dn = '0;
  logic [4:0] st;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int lat [5] = '{1, 1, 1, 1, 1};
  int rem [5] = '{0, 0, 0, 0, 0};
  int withhold_rnd = 0;
  int inj_rnd = 0;
  int last_path = 0;
  int last_ks = 0;
  int n_sb = 0, n_sr = 0, n_mc = 0, n_ark = 0, n_ks = 0;
  logic [11:0] rc_q [$];
  int done_q [$];
  logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
  vec_t vecs [5];

  assign start_i = start_main | start_inj;
  assign st = {ks_start_o, ark_start_o, mc_start_o, sr_start_o, sb_start_o};
  assign sb_done_i  = dn[0];
  assign sr_done_i  = dn[1] | sr_spur;
  assign mc_done_i  = dn[2];
  assign ark_done_i = dn[3];
  assign ks_done_i  = dn[4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes128_round_ctrl dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .round_o(round_o), .rcon_o(rcon_o),
    .sb_start_o(sb_start_o), .sr_start_o(sr_start_o),
    .mc_start_o(mc_start_o), .ark_start_o(ark_start_o),
    .ks_start_o(ks_start_o),
    .sb_done_i(sb_done_i), .sr_done_i(sr_done_i),
    .mc_done_i(mc_done_i), .ark_done_i(ark_done_i),
    .ks_done_i(ks_done_i)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int exp_lat(input vec_t v);
    int t, p;
    t = 1 + v.lark + 1;
    for (int r = 1; r <= N; r++) begin
      if (r < N) p = v.lsb + 1 + v.lsr + 1 + v.lmc;
      else p = v.lsb + 1 + v.lsr;
      t += ((p > v.lks) ? p : v.lks) + 1 + v.lark + 1;
    end
    return t;
  endfunction

  // Monitor/scoreboard, then unit models answering after lat[] cycles.
  always @(negedge clk) begin
    logic [11:0] e;
    int d;
    if (sb_start_o) n_sb++;
    if (sr_start_o) n_sr++;
    if (mc_start_o) n_mc++;
    if (ks_start_o) n_ks++;
    if (ark_start_o) begin
      n_ark++;
      if (round_o != 0) begin
        d = (last_path > last_ks) ? last_path : last_ks;
        chk("ark_gap", cyc, d + 1);
      end
    end
    if (ks_start_o) begin
      if (rc_q.size() == 0) begin
        errors++; checks++;
        $display("FAIL ks_extra: unexpected ks_start in round %0d", round_o);
      end else begin
        e = rc_q.pop_front();
        chk("ks_round", round_o, e[11:8]);
        chk("ks_rcon", rcon_o, e[7:0]);
      end
    end
    if (done_o) begin
      if (done_q.size() == 0) begin
        errors++; checks++;
        $display("FAIL done_extra: unexpected done_o at cycle %0d", cyc);
      end else begin
        chk("done_cycle", cyc, done_q.pop_front());
      end
    end
    if (!busy_o) begin
      for (int i = 0; i < 5; i++) rem[i] = 0;
      dn = '0;
      sr_spur = 1'b0;
      start_inj = 1'b0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        dn[i] = 1'b0;
        if (rem[i] > 0) begin
          rem[i]--;
          if (rem[i] == 0) dn[i] = 1'b1;
        end
        if (st[i] && !(i == 2 && round_o == 4'(withhold_rnd)))
          rem[i] = lat[i];
      end
      if (dn[2] || (dn[1] && round_o == 4'(N))) last_path = cyc;
      if (dn[4]) last_ks = cyc;
      sr_spur   = sb_start_o && (round_o == 4'(inj_rnd));
      start_inj = sb_start_o && (round_o == 4'(inj_rnd));
    end
  end

  task automatic kick(input vec_t v, input bit want_done);
    lat = '{v.lsb, v.lsr, v.lmc, v.lark, v.lks};
    inj_rnd = v.inj;
    @(negedge clk);
    start_main = 1'b1;
    if (want_done) done_q.push_back(cyc + exp_lat(v));
    for (int r = 1; r <= N; r++) rc_q.push_back({4'(r), rcon_tab[r-1]});
    @(negedge clk);
    start_main = 1'b0;
    chk("ark0_start", ark_start_o, 1);
    chk("ark0_round", round_o, 0);
    chk("ark0_rcon", rcon_o, 8'h01);
    chk("ark0_busy", busy_o, 1);
    chk("ark0_err", err_o, 0);
  endtask

  task automatic run_block(input vec_t v);
    int b0, b1, b2, b3, b4, errs_seen;
    bit got;
    b0 = n_sb; b1 = n_sr; b2 = n_mc; b3 = n_ark; b4 = n_ks;
    kick(v, 1'b1);
    got = 1'b0;
    errs_seen = 0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      if (err_o) errs_seen++;
      if (done_o) got = 1'b1;
    end
    chk("done_seen", got, 1);
    chk("done_busy", busy_o, 1);
    chk("no_err", errs_seen, 0);
    @(negedge clk);
    chk("idle_busy", busy_o, 0);
    chk("done_pulse", done_o, 0);
    chk("final_round", round_o, N);
    chk("final_rcon", rcon_o, 8'h36);
    chk("n_sb", n_sb - b0, v.nsb);
    chk("n_sr", n_sr - b1, v.nsr);
    chk("n_mc", n_mc - b2, v.nmc);
    chk("n_ark", n_ark - b3, v.nark);
    chk("n_ks", n_ks - b4, v.nks);
    chk("sb_left", rc_q.size() + done_q.size(), 0);
    rc_q.delete();
    done_q.delete();
  endtask

  initial begin
    int t_mc, t_err, b;
    bit hit;
    vecs[0] = '{1, 1, 1, 1, 1, 0, 10, 10, 9, 11, 10};
    vecs[1] = '{16, 1, 1, 1, 3, 0, 10, 10, 9, 11, 10};
    vecs[2] = '{1, 1, 1, 1, 40, 0, 10, 10, 9, 11, 10};
    vecs[3] = '{2, 3, 4, 5, 12, 0, 10, 10, 9, 11, 10};
    vecs[4] = '{1, 1, 1, 1, 1, 5, 10, 10, 9, 11, 10};

    repeat (3) @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_round", round_o, 0);
    chk("rst_rcon", rcon_o, 8'h01);
    chk("rst_starts", st, 0);
    rst_i = 1'b0;

    for (int k = 0; k < 5; k++) run_block(vecs[k]);

    // Watchdog: MixColumns never answers in round 3.
    withhold_rnd = 3;
    kick(vecs[0], 1'b0);
    hit = 1'b0;
    t_mc = 0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge clk);
      if (mc_start_o && round_o == 4'd3) begin
        hit = 1'b1;
        t_mc = cyc;
      end
    end
    chk("wd_mc_seen", hit, 1);
    hit = 1'b0;
    t_err = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (err_o) begin
        hit = 1'b1;
        t_err = cyc;
      end
    end
    chk("wd_err", hit, 1);
    chk("wd_window", (t_err - t_mc >= TO) && (t_err - t_mc <= TO + 2), 1);
    chk("wd_busy", busy_o, 0);
    b = n_sb + n_sr + n_mc + n_ark + n_ks;
    repeat (20) @(negedge clk);
    chk("wd_no_starts", n_sb + n_sr + n_mc + n_ark + n_ks - b, 0);
    chk("wd_err_hold", err_o, 1);
    withhold_rnd = 0;
    rc_q.delete();
    done_q.delete();
    run_block(vecs[0]);

    // Reset in the middle of round 7's MixColumns.
    kick(vecs[0], 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge clk);
      if (mc_start_o && round_o == 4'd7) hit = 1'b1;
    end
    chk("rst_mc7_seen", hit, 1);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_done", done_o, 0);
    chk("mid_rst_err", err_o, 0);
    chk("mid_rst_round", round_o, 0);
    chk("mid_rst_rcon", rcon_o, 8'h01);
    chk("mid_rst_starts", st, 0);
    rc_q.delete();
    done_q.delete();
    repeat (2) @(negedge clk);
    chk("mid_rst_idle", busy_o, 0);
    run_block(vecs[3]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
